// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI port between N_REQ engines with an idle gap and a grant watchdog.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise lowest requesting index wins.
module spi_bus_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 200000,
    parameter int GAP     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [N_REQ-1:0] m_spi_clk,
    input  logic [N_REQ-1:0] m_spi_mosi,
    input  logic [N_REQ-1:0] m_spi_le,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic [N_REQ-1:0] timeout_err,
    output logic             spi_clk,
    output logic             spi_mosi,
    output logic             spi_le,
    input  logic             spi_miso
);

    localparam int MAXC = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    winIdx;
    logic [IW-1:0]    scanIdx;
    logic [N_REQ-1:0] winOh;
    logic             ownerDone;
    logic             ownerReq;
    logic             timeoutHit;
    logic             unused_miso;

    // MISO is broadcast to all engines outside this block.
    assign unused_miso = spi_miso;

`ifdef SPI_ARB_RR_EN
    logic [IW-1:0] last_q;

    // Search starts just after the previous owner; the owner itself is scanned last.
    always_comb begin
        winIdx  = '0;
        scanIdx = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            scanIdx = IW'((int'(last_q) + off) % N_REQ);
            if (req[scanIdx]) winIdx = scanIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N_REQ - 1);
        end else if (state_q == S_IDLE && |req) begin
            last_q <= winIdx;
        end
    end
`else
    always_comb begin
        winIdx  = '0;
        scanIdx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scanIdx = IW'(i);
            if (req[scanIdx]) winIdx = scanIdx;
        end
    end
`endif

    assign winOh      = N_REQ'(1) << winIdx;
    assign ownerDone  = |(done & gnt_q);
    assign ownerReq   = |(req & gnt_q);
    assign timeoutHit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Done and voluntary release both take priority over the watchdog.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    gnt_d   = winOh;
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                cnt_d = cnt_q + CW'(1);
                if (ownerDone || !ownerReq) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (timeoutHit) begin
                    gnt_d   = '0;
                    err_d   = err_q | gnt_q;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pins follow the registered grant, so reset idles them without waiting for a clock.
    assign spi_clk     = |(gnt_q & m_spi_clk);
    assign spi_mosi    = |(gnt_q & m_spi_mosi);
    assign spi_le      = ~|(gnt_q & ~m_spi_le);
    assign gnt         = gnt_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: randomized bench for spi_bus_arbiter; a monitor checks grants,
// grant lengths, gaps, pin muxing and error flags against a queued reference model.
module tb_spi_bus_arbiter;

    localparam int N    = 3;
    localparam int TMO  = 100;
    localparam int GAPC = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] mClk = '0;
    logic [N-1:0] mMosi = '0;
    logic [N-1:0] mLe = '1;
    logic         spiMiso = 1'b0;
    logic [N-1:0] gnt;
    logic [N-1:0] timeoutErr;
    logic         busy;
    logic         spiClk;
    logic         spiMosi;
    logic         spiLe;

    typedef struct {
        int           owner;
        int           len;
        logic [N-1:0] err;
    } expT;

    expT          expQ[$];
    expT          cur;
    int           checks = 0;
    int           failures = 0;
    logic [N-1:0] reqMask = '0;
    logic [N-1:0] expErr = '0;
    int           lastOwner = N - 1;
    int           grantNum = 0;
    int           chainCount = 0;
    bit           abortRun = 1'b0;

    spi_bus_arbiter #(.N_REQ(N), .TIMEOUT(TMO), .GAP(GAPC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .m_spi_clk(mClk),
        .m_spi_mosi(mMosi),
        .m_spi_le(mLe),
        .gnt(gnt),
        .busy(busy),
        .timeout_err(timeoutErr),
        .spi_clk(spiClk),
        .spi_mosi(spiMosi),
        .spi_le(spiLe),
        .spi_miso(spiMiso)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Reference arbitration: pick the next requester by scanning the request set.
    function automatic int pickWinner(input logic [N-1:0] m);
        int  w;
        bit  found;
        w = -1;
        found = 1'b0;
`ifdef SPI_ARB_RR_EN
        for (int s = 1; s <= N; s++) begin
            if (!found && m[(lastOwner + s) % N]) begin
                w = (lastOwner + s) % N;
                found = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && m[i]) begin
                w = i;
                found = 1'b1;
            end
        end
`endif
        return w;
    endfunction

    // Monitor: pops an expectation at each new grant and follows it through the gap.
    int monLen = 0;
    int gapLen = 0;
    bit inGrant = 1'b0;
    bit inGap = 1'b0;
    logic [N-1:0] prevGnt = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            inGrant = 1'b0;
            inGap   = 1'b0;
            prevGnt = '0;
        end else begin
            if (gnt != '0 && prevGnt == '0) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_grant: actual gnt=%b expected no grant", gnt);
                end else begin
                    cur = expQ.pop_front();
                    checkOutput("grant_onehot", gnt, longint'(1) << cur.owner);
                    inGrant = 1'b1;
                    inGap   = 1'b0;
                    monLen  = 0;
                end
            end
            if (inGrant) begin
                if (gnt != '0) begin
                    monLen++;
                    checkOutput("pin_mux", {spiClk, spiMosi, spiLe},
                                {mClk[cur.owner], mMosi[cur.owner], mLe[cur.owner]});
                    checkOutput("busy_grant", busy, 1);
                end else begin
                    checkOutput("grant_len", monLen, cur.len);
                    checkOutput("timeout_err", timeoutErr, cur.err);
                    inGrant = 1'b0;
                    inGap   = 1'b1;
                    gapLen  = 0;
                end
            end
            if (gnt == '0) begin
                checkOutput("idle_pins", {spiClk, spiMosi, spiLe}, 3'b001);
            end
            if (inGap) begin
                if (busy && gnt == '0) begin
                    gapLen++;
                end else begin
                    checkOutput("gap_len", gapLen, GAPC);
                    inGap = 1'b0;
                end
            end
            prevGnt = gnt;
        end
    end

    task automatic waitGrant(input int lat);
        int n = 0;
        while (gnt == '0 && n < lat + 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (gnt == '0) begin
            checks++;
            failures++;
            $display("[TB] FAIL grant_wait: actual no grant after %0d cycles, expected grant after %0d", n, lat);
            abortRun = 1'b1;
        end else begin
            checkOutput("grant_latency", n, lat);
        end
    endtask

    // mode: 0 done pulse, 1 voluntary req drop, 2 watchdog expiry, 3 reset mid-frame
    task automatic holdGrant(input int w, input int mode, input int k);
        logic [N-1:0] ownBit;
        ownBit = N'(1) << w;
        for (int c = 0; c <= k; c++) begin
            done  = '0;
            mClk  = N'($urandom);
            mMosi = N'($urandom);
            mLe   = N'($urandom);
            if (c < k) begin
                if ($urandom_range(7) == 0) done = N'($urandom) & ~ownBit;
                if (chainCount < 3 && $urandom_range(29) == 0) begin
                    reqMask = reqMask | (N'(1) << $urandom_range(N - 1));
                    req = reqMask;
                end
            end else if (mode == 0) begin
                done = ownBit;
                reqMask = reqMask & ~ownBit;
                req = reqMask;
            end else if (mode == 1) begin
                reqMask = reqMask & ~ownBit;
                req = reqMask;
            end else if (mode == 3) begin
                mLe  = '0;
                mClk = '1;
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("rst_gnt", gnt, 0);
                checkOutput("rst_pins", {spiClk, spiMosi, spiLe}, 3'b001);
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_err", timeoutErr, 0);
                expQ.delete();
                expErr = '0;
                lastOwner = N - 1;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        done = '0;
        if (mode == 2) begin
            reqMask = reqMask & ~ownBit;
            req = reqMask;
        end
    endtask

    // Serves every pending request in arbitration order, then lets the bus settle.
    task automatic applyStimulus(input int firstLat);
        int  lat;
        int  w;
        int  mode;
        int  k;
        int  r;
        expT e;
        lat = firstLat;
        chainCount = 0;
        while (reqMask != '0 && !abortRun) begin
            w = pickWinner(reqMask);
            grantNum++;
            chainCount++;
            r = int'($urandom_range(15));
            mode = (r < 3) ? 1 : ((r == 3) ? 2 : 0);
            if (grantNum == 3) mode = 2;
            if (grantNum == 5) mode = 0;
            if (grantNum == 8) mode = 3;
            k = int'($urandom_range(59));
            if (mode == 2 || grantNum == 5) k = TMO - 1;
            if (mode == 3) k = int'($urandom_range(20, 3));
            if (mode == 2) expErr = expErr | (N'(1) << w);
            e.owner = w;
            e.len = k + 1;
            e.err = expErr;
            lastOwner = w;
            expQ.push_back(e);
            waitGrant(lat);
            if (abortRun) break;
            holdGrant(w, mode, k);
            lat = (mode == 3) ? 1 : GAPC + 1;
        end
        repeat (GAPC + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_err", timeoutErr, 0);
        checkOutput("reset_pins", {spiClk, spiMosi, spiLe}, 3'b001);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 30 && !abortRun; t++) begin
            reqMask = N'($urandom_range((1 << N) - 1, 1));
            req = reqMask;
            applyStimulus(1);
        end
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
